// File: rtl/sd_test_pkg.sv
// Shared definitions for the multi-sector SD tester: FSM states, pattern
// mode encoding and LFSR constants. Optional loop mode: SD_TEST_LOOP_EN.
package sd_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_START,
    WR_WAIT,
    RD_START,
    RD_WAIT,
    NEXT,
    DONE
  } state_t;

  typedef enum logic {
    PAT_INC  = 1'b0,
    PAT_LFSR = 1'b1
  } pat_mode_t;

  // Right-shifting Fibonacci LFSR tap masks (bit 0 is the output end).
  // 16 bit: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;
  // 32 bit: x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS_32 = 32'hC000_0401;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/sd_pat_gen.sv
// Pattern generator for one sector: load seeds word 0 for sector 'sec',
// advance steps to the next word. One instance feeds writes, one feeds compares.
module sd_pat_gen
  import sd_test_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_SEC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  input  logic [15:0]       sec,
  output logic [DATA_W-1:0] word
);

  localparam logic [DATA_W-1:0] TAPS = (DATA_W == 32) ? DATA_W'(LFSR_TAPS_32)
                                                      : DATA_W'(LFSR_TAPS_16);

  logic [15:0]       seed16;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] next_word;

  // Word 0 of the sector and the successor of the current word.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    seed16 = sec ^ LFSR_SEED;
    if (seed16 == 16'd0) seed16 = 16'd1;
    load_word = DATA_W'(32'(sec) * 32'(WORDS_PER_SEC));
    next_word = word + DATA_W'(1);
    if (mode == PAT_LFSR) begin
      load_word = DATA_W'(seed16);
      next_word = {^(word & TAPS), word[DATA_W-1:1]};
    end
  end

  // Current pattern word register.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (advance) begin
      word <= next_word;
    end
  end

endmodule

// File: rtl/sd_multi_sec_tester.sv
// Multi-sector SD write/read-back tester. Writes a pattern to SEC_NUM sectors
// from START_SEC, reads each back and counts mismatching words.
// Define SD_TEST_LOOP_EN to restart automatically after every run (soak test).
module sd_multi_sec_tester
  import sd_test_pkg::*;
#(
  parameter int          DATA_W        = 16,
  parameter int          WORDS_PER_SEC = 256,
  parameter logic [31:0] START_SEC     = 32'd2000,
  parameter int          SEC_NUM       = 4,
  parameter logic [23:0] TIMEOUT       = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sd_init_done,
  input  logic              pat_mode,
  output logic              wr_start_en,
  output logic [31:0]       wr_sec_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_busy,
  input  logic              wr_req,
  output logic              rd_start_en,
  output logic [31:0]       rd_sec_addr,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [DATA_W-1:0] rd_val_data,
  output logic              done,
  output logic              error_flag,
  output logic [15:0]       err_cnt,
  output logic [15:0]       pass_cnt
);

  state_t            state;
  pat_mode_t         mode_q;
  logic              init_d;
  logic              busy_seen;
  logic [15:0]       sec_idx;
  logic [15:0]       word_cnt;
  logic [23:0]       tmo_cnt;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  logic        rd_fire;
  logic        mismatch;
  logic        rd_end;
  logic        short_sec;
  logic        tmo_hit;
  logic [16:0] rd_total;
  logic [16:0] err_sum;
  logic [15:0] err_next;

  sd_pat_gen #(.DATA_W(DATA_W), .WORDS_PER_SEC(WORDS_PER_SEC)) u_wr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (state == WR_START),
    .advance ((state == WR_WAIT) && wr_req),
    .mode    (mode_q),
    .sec     (sec_idx),
    .word    (wr_word)
  );

  sd_pat_gen #(.DATA_W(DATA_W), .WORDS_PER_SEC(WORDS_PER_SEC)) u_rd_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (state == RD_START),
    .advance ((state == RD_WAIT) && rd_val_en),
    .mode    (mode_q),
    .sec     (sec_idx),
    .word    (rd_word)
  );

  // Read-back checks and saturating error accumulation for this cycle.
  always_comb begin
    rd_fire   = (state == RD_WAIT) && rd_val_en;
    mismatch  = rd_fire && (rd_val_data != rd_word);
    rd_end    = (state == RD_WAIT) && busy_seen && !rd_busy;
    rd_total  = {1'b0, word_cnt} + {16'd0, rd_fire};
    short_sec = rd_end && (rd_total != 17'(WORDS_PER_SEC));
    tmo_hit   = ((state == WR_WAIT) || (state == RD_WAIT)) && (tmo_cnt == TIMEOUT - 24'd1);
    err_sum   = {1'b0, err_cnt} + {16'd0, mismatch} + {16'd0, short_sec};
    err_next  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Test sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= PAT_INC;
      init_d      <= 1'b0;
      busy_seen   <= 1'b0;
      sec_idx     <= '0;
      word_cnt    <= '0;
      tmo_cnt     <= '0;
      wr_start_en <= 1'b0;
      wr_sec_addr <= '0;
      wr_data     <= '0;
      rd_start_en <= 1'b0;
      rd_sec_addr <= '0;
      done        <= 1'b0;
      error_flag  <= 1'b0;
      err_cnt     <= '0;
      pass_cnt    <= '0;
    end else begin
      init_d      <= sd_init_done;
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      if ((state != IDLE) && !sd_init_done) begin
        // Controller lost initialisation: abandon the run, keep the error count.
        state <= IDLE;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sd_init_done && !init_d) begin
              mode_q   <= pat_mode_t'(pat_mode);
              err_cnt  <= '0;
              sec_idx  <= '0;
              word_cnt <= '0;
              done     <= 1'b0;
              state    <= WR_START;
            end
          end
          WR_START: begin
            wr_start_en <= 1'b1;
            wr_sec_addr <= START_SEC + {16'd0, sec_idx};
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            busy_seen   <= 1'b0;
            state       <= WR_WAIT;
          end
          WR_WAIT: begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (wr_busy) busy_seen <= 1'b1;
            if (wr_req) begin
              wr_data  <= wr_word;
              word_cnt <= word_cnt + 16'd1;
            end
            if (tmo_hit) begin
              error_flag <= 1'b1;
              err_cnt    <= 16'hFFFF;
              done       <= 1'b1;
              state      <= DONE;
            end else if (busy_seen && !wr_busy) begin
              word_cnt <= '0;
              state    <= RD_START;
            end
          end
          RD_START: begin
            rd_start_en <= 1'b1;
            rd_sec_addr <= START_SEC + {16'd0, sec_idx};
            tmo_cnt     <= '0;
            busy_seen   <= 1'b0;
            state       <= RD_WAIT;
          end
          RD_WAIT: begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (rd_busy) busy_seen <= 1'b1;
            if (rd_fire) word_cnt <= word_cnt + 16'd1;
            if (mismatch || short_sec) begin
              err_cnt    <= err_next;
              error_flag <= 1'b1;
            end
            if (tmo_hit) begin
              error_flag <= 1'b1;
              err_cnt    <= 16'hFFFF;
              done       <= 1'b1;
              state      <= DONE;
            end else if (rd_end) begin
              word_cnt <= '0;
              state    <= NEXT;
            end
          end
          NEXT: begin
            if (sec_idx == 16'(SEC_NUM - 1)) begin
              done <= 1'b1;
              if (err_cnt == 16'd0) pass_cnt <= pass_cnt + 16'd1;
              state <= DONE;
            end else begin
              sec_idx <= sec_idx + 16'd1;
              state   <= WR_START;
            end
          end
          DONE: begin
`ifdef SD_TEST_LOOP_EN
            done    <= 1'b0;
            sec_idx <= '0;
            err_cnt <= '0;
            mode_q  <= pat_mode_t'(pat_mode);
            state   <= WR_START;
`else
            state   <= DONE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
